// File: rtl/timer_tc_pkg.sv
// Shared definitions for the timer/counter peripheral: FSM states, register
// offsets, CTRL bit positions and mode encodings.
package timer_tc_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CNT  = 2'd1,
        INT  = 2'd2
    } state_t;

    localparam logic [1:0] CTRL_OFF   = 2'd0;
    localparam logic [1:0] PRESET_OFF = 2'd1;
    localparam logic [1:0] COUNT_OFF  = 2'd2;

    localparam int EN      = 0;
    localparam int MODE_LO = 1;
    localparam int MODE_HI = 2;
    localparam int IM      = 3;

    localparam logic [1:0] ONE_SHOT    = 2'b00;
    localparam logic [1:0] AUTO_RELOAD = 2'b01;

endpackage

// File: rtl/timer_tc_byte_merge.sv
// Combinational byte-lane merge: lanes with byteen set take wdata, the
// others keep the old register value.
module byte_merge (
    input  logic [31:0] old_val,
    input  logic [31:0] wdata,
    input  logic [3:0]  byteen,
    output logic [31:0] merged
);

    always_comb begin
        merged = old_val;
        for (int i = 0; i < 4; i++) begin
            if (byteen[i]) begin
                merged[8*i +: 8] = wdata[8*i +: 8];
            end
        end
    end

endmodule

// File: rtl/timer_tc.sv
// Memory-mapped countdown timer with one-shot / auto-reload modes and a
// maskable interrupt request.
module timer_tc
    import timer_tc_pkg::*;
#(
    parameter logic [31:0] BASE = 32'h0000_7f00
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic        we,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        irq
);

    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic        irq_flag;
    state_t      state;
    state_t      state_next;

    logic        sel;
    logic [1:0]  off;
    logic        wr_ctrl;
    logic        wr_preset;
    logic [31:0] preset_merged;
    logic        unused_addr;

    logic [31:0] count_next;
    logic        flag_set;
    logic        flag_clr;
    logic        en_clr;

    assign sel         = (addr[31:4] == BASE[31:4]);
    assign off         = addr[3:2];
    assign unused_addr = ^addr[1:0];
    assign wr_ctrl     = sel && we && (off == CTRL_OFF) && (|byteen);
    assign wr_preset   = sel && we && (off == PRESET_OFF) && (|byteen);

    byte_merge u_preset_merge (
        .old_val (preset),
        .wdata   (wdata),
        .byteen  (byteen),
        .merged  (preset_merged)
    );

    always_comb begin
        state_next = state;
        count_next = count;
        flag_set   = 1'b0;
        flag_clr   = 1'b0;
        en_clr     = 1'b0;
        case (state)
            IDLE: begin
                if (ctrl[EN]) begin
                    count_next = preset;
                    state_next = CNT;
                end
            end
            CNT: begin
                if (!ctrl[EN]) begin
                    state_next = IDLE;
                end else if (count > 32'd1) begin
                    count_next = count - 32'd1;
                end else begin
                    count_next = 32'd0;
                    flag_set   = 1'b1;
                    state_next = INT;
                end
            end
            INT: begin
                // Modes 10 and 11 fall into the one-shot branch.
                if (ctrl[MODE_HI:MODE_LO] == AUTO_RELOAD) begin
                    flag_clr   = 1'b1;
                    count_next = preset;
                    state_next = CNT;
                end else begin
                    en_clr     = 1'b1;
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            count <= 32'd0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    // A bus write to CTRL overrides the one-shot EN clear in the same cycle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ctrl <= 4'd0;
        end else if (wr_ctrl && byteen[0]) begin
            ctrl <= wdata[3:0];
        end else if (en_clr) begin
            ctrl[EN] <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            preset <= 32'd0;
        end else if (wr_preset) begin
            preset <= preset_merged;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            irq_flag <= 1'b0;
        end else if (wr_ctrl || wr_preset || flag_clr) begin
            irq_flag <= 1'b0;
        end else if (flag_set) begin
            irq_flag <= 1'b1;
        end
    end

    always_comb begin
        rdata = 32'd0;
        if (sel) begin
            case (off)
                CTRL_OFF:   rdata = {28'd0, ctrl};
                PRESET_OFF: rdata = preset;
                COUNT_OFF:  rdata = count;
                default:    rdata = 32'd0;
            endcase
        end
    end

    assign irq = irq_flag & ctrl[IM];

endmodule

// File: tb/tb_timer_tc.sv
// Directed self-checking bench for timer_tc: register table vectors plus
// hand-written counting, reload, pause and reset sequences.
module tb_timer_tc;

    localparam logic [31:0] BASE     = 32'h0000_7f00;
    localparam logic [31:0] CTRL_A   = BASE;
    localparam logic [31:0] PRESET_A = BASE + 32'h4;
    localparam logic [31:0] COUNT_A  = BASE + 32'h8;
    localparam logic [31:0] RSV_A    = BASE + 32'hC;
    localparam logic [31:0] OOW_A    = BASE + 32'h10;

    logic        clk;
    logic        reset;
    logic [31:0] addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_write;
        logic [31:0] a;
        logic [3:0]  be;
        logic [31:0] d;
        logic [31:0] exp;
        string       name;
    } vec_t;

    vec_t vecs[20];

    timer_tc #(.BASE(BASE)) dut (
        .clk    (clk),
        .reset  (reset),
        .addr   (addr),
        .we     (we),
        .byteen (byteen),
        .wdata  (wdata),
        .rdata  (rdata),
        .irq    (irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_irq(input string name, input logic exp);
        check_output(name, {31'd0, irq}, {31'd0, exp});
    endtask

    task automatic bus_write(input logic [31:0] a, input logic [3:0] be, input logic [31:0] d);
        @(negedge clk);
        addr   = a;
        byteen = be;
        wdata  = d;
        we     = 1'b1;
        @(posedge clk);
        #1;
        we     = 1'b0;
        byteen = 4'd0;
    endtask

    task automatic bus_read(input logic [31:0] a, input logic [31:0] exp, input string name);
        addr = a;
        #1;
        check_output(name, rdata, exp);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input vec_t v);
        if (v.is_write) bus_write(v.a, v.be, v.d);
        else            bus_read(v.a, v.exp, v.name);
    endtask

    initial begin
        vecs[0]  = '{1'b1, PRESET_A,     4'hF, 32'h1122_3344, 32'h0,          "wr_preset"};
        vecs[1]  = '{1'b0, PRESET_A,     4'h0, 32'h0,         32'h1122_3344,  "preset_full"};
        vecs[2]  = '{1'b1, PRESET_A,     4'h2, 32'h0000_AA00, 32'h0,          "wr_preset_byte1"};
        vecs[3]  = '{1'b0, PRESET_A,     4'h0, 32'h0,         32'h1122_AA44,  "preset_byte1"};
        vecs[4]  = '{1'b1, COUNT_A,      4'hF, 32'hFFFF_FFFF, 32'h0,          "wr_count"};
        vecs[5]  = '{1'b0, COUNT_A,      4'h0, 32'h0,         32'h0,          "count_ro"};
        vecs[6]  = '{1'b1, OOW_A,        4'hF, 32'hDEAD_BEEF, 32'h0,          "wr_oow"};
        vecs[7]  = '{1'b0, OOW_A,        4'h0, 32'h0,         32'h0,          "out_of_window"};
        vecs[8]  = '{1'b0, PRESET_A,     4'h0, 32'h0,         32'h1122_AA44,  "preset_after_oow"};
        vecs[9]  = '{1'b1, RSV_A,        4'hF, 32'h0000_0005, 32'h0,          "wr_reserved"};
        vecs[10] = '{1'b0, RSV_A,        4'h0, 32'h0,         32'h0,          "reserved"};
        vecs[11] = '{1'b1, CTRL_A,       4'hE, 32'h0000_000F, 32'h0,          "wr_ctrl_masked"};
        vecs[12] = '{1'b0, CTRL_A,       4'h0, 32'h0,         32'h0,          "ctrl_be_masked"};
        vecs[13] = '{1'b1, CTRL_A,       4'hF, 32'hFFFF_FFF6, 32'h0,          "wr_ctrl_upper"};
        vecs[14] = '{1'b0, CTRL_A,       4'h0, 32'h0,         32'h6,          "ctrl_upper_zero"};
        vecs[15] = '{1'b0, BASE + 32'h7, 4'h0, 32'h0,         32'h1122_AA44,  "addr_low_ignored"};
        vecs[16] = '{1'b1, CTRL_A,       4'hF, 32'h0,         32'h0,          "wr_ctrl_zero"};
        vecs[17] = '{1'b0, CTRL_A,       4'h0, 32'h0,         32'h0,          "ctrl_cleared"};
        vecs[18] = '{1'b1, PRESET_A,     4'h0, 32'hFFFF_FFFF, 32'h0,          "wr_preset_no_be"};
        vecs[19] = '{1'b0, PRESET_A,     4'h0, 32'h0,         32'h1122_AA44,  "preset_be_none"};

        reset  = 1'b0;
        we     = 1'b0;
        byteen = 4'd0;
        wdata  = 32'd0;
        addr   = 32'd0;

        // Writes during reset must be ignored.
        bus_write(CTRL_A, 4'hF, 32'h0000_000F);
        bus_read(CTRL_A, 32'h0, "rst_ctrl_held");
        check_irq("rst_irq_held", 1'b0);
        bus_read(PRESET_A, 32'h0, "rst_preset_held");
        @(negedge clk);
        reset = 1'b1;
        step(2);
        bus_read(CTRL_A, 32'h0, "rst_ctrl");
        bus_read(PRESET_A, 32'h0, "rst_preset");
        bus_read(COUNT_A, 32'h0, "rst_count");
        check_irq("rst_irq", 1'b0);

        for (int i = 0; i < 20; i++) apply_stimulus(vecs[i]);

        // One-shot, N=5: COUNT 5..1 at E1..E5, irq at E6, EN cleared at E7.
        bus_write(PRESET_A, 4'hF, 32'd5);
        bus_write(CTRL_A, 4'hF, 32'h9);
        for (int k = 1; k <= 5; k++) begin
            step(1);
            bus_read(COUNT_A, 32'(6 - k), "oneshot_count");
            check_irq("oneshot_irq_low", 1'b0);
        end
        step(1);
        check_irq("oneshot_irq_rise", 1'b1);
        bus_read(COUNT_A, 32'h0, "oneshot_count_zero");
        step(1);
        bus_read(CTRL_A, 32'h8, "oneshot_en_cleared");
        step(3);
        check_irq("oneshot_irq_hold", 1'b1);
        bus_write(CTRL_A, 4'hF, 32'h8);
        check_irq("oneshot_irq_clear", 1'b0);

        // Auto-reload, N=3: irq pulse at E4, E8, E12.
        bus_write(PRESET_A, 4'hF, 32'd3);
        bus_write(CTRL_A, 4'hF, 32'hB);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check_irq("auto_irq", (k % 4) == 0);
            bus_read(COUNT_A, ((k % 4) == 0) ? 32'd0 : 32'(4 - (k % 4)), "auto_count");
        end
        bus_write(CTRL_A, 4'hF, 32'h0);
        step(2);

        // Same sequence masked: FSM runs, irq stays low.
        bus_write(CTRL_A, 4'hF, 32'h3);
        for (int k = 1; k <= 12; k++) begin
            step(1);
            check_irq("masked_irq", 1'b0);
            bus_read(COUNT_A, ((k % 4) == 0) ? 32'd0 : 32'(4 - (k % 4)), "masked_count");
        end
        bus_write(CTRL_A, 4'hF, 32'h0);
        step(2);

        // Pause: the EN clear lands on the edge where COUNT becomes 7.
        bus_write(PRESET_A, 4'hF, 32'd10);
        bus_write(CTRL_A, 4'hF, 32'h9);
        step(3);
        bus_read(COUNT_A, 32'd8, "pause_pre");
        bus_write(CTRL_A, 4'hF, 32'h8);
        bus_read(COUNT_A, 32'd7, "pause_at7");
        step(3);
        bus_read(COUNT_A, 32'd7, "pause_hold");
        bus_write(CTRL_A, 4'hF, 32'h9);
        step(1);
        bus_read(COUNT_A, 32'd10, "resume_reload");
        step(1);
        bus_read(COUNT_A, 32'd9, "resume_dec");
        bus_write(CTRL_A, 4'hF, 32'h0);
        step(2);

        // Preset 0 reaches INT at E2.
        bus_write(PRESET_A, 4'hF, 32'd0);
        bus_write(CTRL_A, 4'hF, 32'h9);
        step(1);
        check_irq("p0_irq_e1", 1'b0);
        bus_read(COUNT_A, 32'd0, "p0_count_e1");
        step(1);
        check_irq("p0_irq_e2", 1'b1);

        // Reset asserted between edges while irq is high.
        #1;
        reset = 1'b0;
        #1;
        check_irq("rst_async_irq", 1'b0);
        bus_read(CTRL_A, 32'h0, "rst_async_ctrl");
        bus_read(PRESET_A, 32'h0, "rst_async_preset");
        bus_read(COUNT_A, 32'h0, "rst_async_count");
        @(negedge clk);
        reset = 1'b1;
        step(2);
        check_irq("post_rst_irq", 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
